life_gen_ctrl: RTL and testbench
================================

# life_gen_ctrl

Generation sequencer for the Life engine. It scans a double-buffered X×Y one-bit board in raster order and feeds each cell into the row-delay shift pipe, one cell per cycle. It then flushes the pipe and issues aligned write-back addresses with board-edge flags for the 3×3 neighbour datapath, repeating for a requested number of generations.

## Interface
Parameters:
- X, 8, board width in cells; power of two, ≥2
- Y, 8, board height in cells; power of two, ≥2
- LOG2X, 3, log2(X)
- LOG2Y, 3, log2(Y)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- start  in  1  begin a run; sampled only in IDLE
- gens  in  16  number of generations to run; sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at the end of a run
- rd_en  out  1  board read strobe
- rd_addr  out  LOG2X+LOG2Y  read address {row,col}
- rd_data  in  1  cell value; valid one cycle after rd_en
- pipe_in  out  1  to the pipe's new_data input
- wr_en  out  1  write-back strobe for the centre cell
- wr_addr  out  LOG2X+LOG2Y  centre cell address {row,col}
- edge_n, edge_s, edge_w, edge_e  out  1 each  centre is on row 0 / row Y-1 / col 0 / col X-1
- bank  out  1  read bank; the write bank is ~bank
- gen_cnt  out  16  generations completed in the current run

## Operation
- States: IDLE, RUN, FLUSH, DRAIN.
- Reset values: state=IDLE; all outputs 0, including bank and gen_cnt.
- IDLE:
  - start with gens=0: done pulses next cycle; busy stays 0.
  - start with gens≠0: latch gens, clear gen_cnt, enter RUN with index i=0.
- RUN, i = 0..X·Y-1:
  - rd_en=1, rd_addr=i, i increments each cycle.
  - After i=X·Y-1, enter FLUSH.
- FLUSH, i = X·Y..X·Y+X:
  - rd_en=0; i keeps counting.
  - After i=X·Y+X, enter DRAIN.
- DRAIN, one cycle:
  - Carries the last write. gen_cnt increments.
  - If gen_cnt+1 < gens: toggle bank, enter RUN with i=0.
  - Otherwise: enter IDLE and pulse done in the next cycle.
- pipe_in = rd_data when rd_en was high in the previous cycle, else 0. The pipe shifts every cycle, so zeros are forced during FLUSH and DRAIN.
- Write-back is registered one cycle after index i:
  - wr_en = (i ≥ X+1)
  - wr_addr = i-X-1
  - edge flags decoded from wr_addr
- Exactly X·Y writes per generation, addresses 0..X·Y-1, in order.
- busy=1 in RUN, FLUSH and DRAIN.
- start is ignored while busy.
- Reset asserted mid-run: next cycle IDLE, all outputs 0, bank=0. No partial-generation completion.

## Timing
- Start sampled at cycle 0; index i is presented at cycle i+1 of the first generation.
- rd_en covers cycles 1..X·Y; FLUSH covers cycles X·Y+1..X·Y+X+1; DRAIN is cycle X·Y+X+2.
- wr_en for index i is at cycle i+2, so writes occupy cycles X+3..X·Y+X+2.
- Generation length is X·Y+X+2 cycles (74 for 8×8). The next generation's first rd_en follows DRAIN with no gap, and bank toggles in that same cycle.
- done is at cycle gens·(X·Y+X+2)+1. busy falls in the same cycle that done rises.
- Bank hazard: the last write of generation n is in bank ~b at DRAIN; generation n+1 reads bank ~b from the next cycle, so write-before-read ordering holds.

## Structure
- Package life_pkg holds:
  - the state enum {IDLE, RUN, FLUSH, DRAIN}
  - ADDR_W = LOG2X+LOG2Y
  - the GEN_W=16 constant
- Sub-module life_scan_cnt:
  - row/col index counter with clear and enable
  - outputs the flattened index and the terminal flags X·Y-1 and X·Y+X
  - instantiated once for the read index; write-side row/col are derived from the delayed index

## Test plan
- X=Y=8, gens=1, board with a blinker at (3,2),(3,3),(3,4):
  - rd_en for cycles 1..64, addr 0..63
  - wr_en for cycles 11..74, addr 0..63
  - done at cycle 75; busy for cycles 1..74
  - pipe_in matches the board contents delayed by one cycle
- gens=2:
  - bank toggles 0→1 at cycle 75
  - gen_cnt reads 1 after cycle 74 and 2 after cycle 148
  - done at cycle 149
  - second-generation reads hit bank 1
- Edge flags:
  - wr_addr 0 → edge_n, edge_w
  - wr_addr 7 → edge_n, edge_e
  - wr_addr 56 → edge_s, edge_w
  - wr_addr 63 → edge_s, edge_e
  - wr_addr 27 → no flags
- gens=0 start: done at cycle 1; busy, rd_en and wr_en never assert.
- start re-pulsed during RUN is ignored:
  - reset at cycle 30 → cycle 31 all outputs 0, IDLE
  - a fresh start then reproduces the first scenario's timing exactly

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Life generation sequencer.
package life_pkg;

  localparam int LOG2X_DEF = 3;
  localparam int LOG2Y_DEF = 3;
  localparam int ADDR_W    = LOG2X_DEF + LOG2Y_DEF;
  localparam int GEN_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } life_state_e;

endpackage

// File: rtl/life_gen_ctrl_if.sv
// Board-side bus of the sequencer: read port, pipe feed, write-back address and edge flags.
// The read port has no handshake: rd_data is valid the cycle after rd_en, unconditionally.
interface life_gen_ctrl_if #(
  parameter int ADDR_W = life_pkg::ADDR_W
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              pipe_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              edge_n;
  logic              edge_s;
  logic              edge_w;
  logic              edge_e;
  logic              bank;

  modport master (
    output rd_en, rd_addr, pipe_in, wr_en, wr_addr,
    output edge_n, edge_s, edge_w, edge_e, bank,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, pipe_in, wr_en, wr_addr,
    input  edge_n, edge_s, edge_w, edge_e, bank,
    output rd_data
  );

endinterface

// File: rtl/life_scan_cnt.sv
// Raster row/col counter. The row field has one spare bit so the index can run past
// the board into the flush region (up to X*Y+X).
module life_scan_cnt #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  output logic [LOG2X+LOG2Y:0]   idx,
  output logic                   last_cell,
  output logic                   flush_end
);

  localparam int IW = LOG2X + LOG2Y + 1;

  logic [LOG2Y:0]   row_q, row_d;
  logic [LOG2X-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      col_d = col_q + 1'b1;
      if (col_q == LOG2X'(X - 1)) row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign idx       = {row_q, col_q};
  assign last_cell = (idx == IW'(X * Y - 1));
  assign flush_end = (idx == IW'(X * Y + X));

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer: raster-reads the board into the row-delay pipe, flushes it,
// and emits write-back addresses X+1 cells behind the read index.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [GEN_W-1:0]      gens,
  output logic                  busy,
  output logic                  done,
  output logic [GEN_W-1:0]      gen_cnt,
  output life_state_e           state_dbg,
  life_gen_ctrl_if.master       bus
);

  localparam int AW = LOG2X + LOG2Y;
  localparam int IW = AW + 1;

  life_state_e      state_q, state_d;
  logic [GEN_W-1:0] gens_q, gens_d;
  logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
  logic             bank_q, bank_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;

  logic             cnt_clr, cnt_en;
  logic [IW-1:0]    idx;
  logic             last_cell, flush_end;

  life_scan_cnt #(.X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y)) u_scan (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .idx       (idx),
    .last_cell (last_cell),
    .flush_end (flush_end)
  );

  always_comb begin
    state_d   = state_q;
    gens_d    = gens_q;
    gen_cnt_d = gen_cnt_q;
    bank_d    = bank_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          if (gens == '0) begin
            done_d = 1'b1;
          end else begin
            gens_d    = gens;
            gen_cnt_d = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (last_cell) state_d = FLUSH;
      end
      FLUSH: begin
        cnt_en = 1'b1;
        if (flush_end) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_clr   = 1'b1;
        gen_cnt_d = gen_cnt_q + 1'b1;
        if (({1'b0, gen_cnt_q} + 17'd1) < {1'b0, gens_q}) begin
          bank_d  = ~bank_q;
          state_d = RUN;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-back trails the read index by X+1 cells; only RUN/FLUSH indices produce writes.
  always_comb begin
    rd_en_d   = (state_q == RUN);
    wr_en_d   = ((state_q == RUN) || (state_q == FLUSH)) && (idx >= IW'(X + 1));
    wr_addr_d = idx[AW-1:0] - AW'(X + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gens_q    <= '0;
      gen_cnt_q <= '0;
      bank_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      gens_q    <= gens_d;
      gen_cnt_q <= gen_cnt_d;
      bank_q    <= bank_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign gen_cnt   = gen_cnt_q;
  assign state_dbg = state_q;

  assign bus.rd_en   = (state_q == RUN);
  assign bus.rd_addr = idx[AW-1:0];
  assign bus.pipe_in = rd_en_q & bus.rd_data;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.bank    = bank_q;

  // Flags are gated so an idle write address of 0 does not look like a corner cell.
  assign bus.edge_n = wr_en_q && (wr_addr_q[AW-1:LOG2X] == '0);
  assign bus.edge_s = wr_en_q && (&wr_addr_q[AW-1:LOG2X]);
  assign bus.edge_w = wr_en_q && (wr_addr_q[LOG2X-1:0] == '0);
  assign bus.edge_e = wr_en_q && (&wr_addr_q[LOG2X-1:0]);

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl: cycle-accurate scoreboard of reads and write-backs over 8x8 runs.
module tb_life_gen_ctrl;
  import life_pkg::*;

  localparam int X = 8;
  localparam int Y = 8;
  localparam int L = X * Y + X + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] gens;
  logic        busy;
  logic        done;
  logic [15:0] gen_cnt;
  life_state_e state_dbg;

  life_gen_ctrl_if #(.ADDR_W(6)) bus ();

  life_gen_ctrl #(.X(X), .Y(Y), .LOG2X(3), .LOG2Y(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .gens      (gens),
    .busy      (busy),
    .done      (done),
    .gen_cnt   (gen_cnt),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        start_bank;
  logic        board [2][64];
  logic [23:0] rd_q[$];
  logic [23:0] wr_q[$];

  // Board memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= board[bus.bank][bus.rd_addr];
    else           bus.rd_data <= 1'($urandom_range(1, 0));
  end

  task automatic run_scenario(input int g, input int abort_at, input int repulse_at);
    int          gl, n_cyc, n, p;
    logic [23:0] e;
    logic        exp_rd, exp_wr, exp_bank, exp_pipe;
    logic [3:0]  exp_edges, got_edges;
    logic [5:0]  a;
    life_state_e exp_st;
    logic [15:0] exp_gc;
    gl = g * L;
    rd_q.delete();
    wr_q.delete();
    for (int gi = 0; gi < g; gi++) begin
      for (int ai = 0; ai < 64; ai++) begin
        if (abort_at == 0 || gi * L + 1 + ai <= abort_at)
          rd_q.push_back({16'(gi * L + 1 + ai), 8'(ai)});
        if (abort_at == 0 || gi * L + X + 3 + ai <= abort_at)
          wr_q.push_back({16'(gi * L + X + 3 + ai), 8'(ai)});
      end
    end
    n_cyc = (abort_at != 0) ? abort_at + 1 : gl + 2;
    @(negedge clk);
    start = 1'b1;
    gens  = 16'(g);
    for (int k = 1; k <= n_cyc; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_at != 0 && k == abort_at + 1) begin
        checks++;
        if ({busy, done, bus.rd_en, bus.wr_en, bus.pipe_in, bus.bank,
             bus.edge_n, bus.edge_s, bus.edge_w, bus.edge_e} !== 10'b0 ||
            gen_cnt !== 16'd0 || bus.rd_addr !== 6'd0 || bus.wr_addr !== 6'd0 ||
            state_dbg !== IDLE) begin
          errors++;
          $display("FAIL mid_run_reset cycle %0d: busy=%b done=%b rd_en=%b wr_en=%b bank=%b gen_cnt=%0d state=%0d, required all zero and IDLE",
                   k, busy, done, bus.rd_en, bus.wr_en, bus.bank, gen_cnt, state_dbg);
        end
        reset      = 1'b0;
        start_bank = 1'b0;
      end else begin
        n = (k - 1) / L;
        p = (k - 1) % L;
        if (g == 0) n = 0;
        else if (n > g - 1) n = g - 1;
        exp_bank = start_bank ^ n[0];

        checks++;
        if (busy !== (k <= gl)) begin
          errors++;
          $display("FAIL busy cycle %0d: got %b required %b", k, busy, (k <= gl));
        end
        checks++;
        if (done !== (k == gl + 1)) begin
          errors++;
          $display("FAIL done cycle %0d: got %b required %b", k, done, (k == gl + 1));
        end
        checks++;
        if (bus.bank !== exp_bank) begin
          errors++;
          $display("FAIL bank cycle %0d: got %b required %b", k, bus.bank, exp_bank);
        end
        if (g > 0) begin
          exp_gc = (k <= gl) ? 16'((k - 1) / L) : 16'(g);
          checks++;
          if (gen_cnt !== exp_gc) begin
            errors++;
            $display("FAIL gen_cnt cycle %0d: got %0d required %0d", k, gen_cnt, exp_gc);
          end
        end
        if (k > gl)        exp_st = IDLE;
        else if (p < 64)   exp_st = RUN;
        else if (p < 73)   exp_st = FLUSH;
        else               exp_st = DRAIN;
        checks++;
        if (state_dbg !== exp_st) begin
          errors++;
          $display("FAIL state cycle %0d: got %0d required %0d", k, state_dbg, exp_st);
        end
        exp_pipe = (k <= gl && p >= 1 && p <= 64) ? board[exp_bank][p - 1] : 1'b0;
        checks++;
        if (bus.pipe_in !== exp_pipe) begin
          errors++;
          $display("FAIL pipe_in cycle %0d: got %b required %b", k, bus.pipe_in, exp_pipe);
        end

        exp_rd = (rd_q.size() > 0) && (int'(rd_q[0][23:8]) == k);
        checks++;
        if (bus.rd_en !== exp_rd) begin
          errors++;
          $display("FAIL rd_en cycle %0d: got %b required %b", k, bus.rd_en, exp_rd);
        end
        if (exp_rd) begin
          e = rd_q.pop_front();
          checks++;
          if (bus.rd_addr !== e[5:0]) begin
            errors++;
            $display("FAIL rd_addr cycle %0d: got %0d required %0d", k, bus.rd_addr, e[5:0]);
          end
        end

        exp_wr = (wr_q.size() > 0) && (int'(wr_q[0][23:8]) == k);
        exp_edges = 4'b0;
        checks++;
        if (bus.wr_en !== exp_wr) begin
          errors++;
          $display("FAIL wr_en cycle %0d: got %b required %b", k, bus.wr_en, exp_wr);
        end
        if (exp_wr) begin
          e = wr_q.pop_front();
          a = e[5:0];
          exp_edges = {a[5:3] == 3'd0, a[5:3] == 3'd7, a[2:0] == 3'd0, a[2:0] == 3'd7};
          checks++;
          if (bus.wr_addr !== a) begin
            errors++;
            $display("FAIL wr_addr cycle %0d: got %0d required %0d", k, bus.wr_addr, a);
          end
        end
        got_edges = {bus.edge_n, bus.edge_s, bus.edge_w, bus.edge_e};
        checks++;
        if (got_edges !== exp_edges) begin
          errors++;
          $display("FAIL edge_flags cycle %0d addr %0d: got nswe=%b required %b",
                   k, bus.wr_addr, got_edges, exp_edges);
        end
      end
      if (k == repulse_at) begin
        start = 1'b1;
        gens  = 16'd5;
      end
      if (k == abort_at) reset = 1'b1;
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: reads %0d writes %0d still queued, required 0 and 0",
               rd_q.size(), wr_q.size());
    end
    if (abort_at == 0 && g > 0) start_bank = start_bank ^ 1'((g - 1) & 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    gens  = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bus.rd_en, bus.wr_en, bus.pipe_in, bus.bank,
         bus.edge_n, bus.edge_s, bus.edge_w, bus.edge_e} !== 10'b0 ||
        gen_cnt !== 16'd0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b rd_en=%b wr_en=%b bank=%b gen_cnt=%0d state=%0d, required all zero and IDLE",
               busy, done, bus.rd_en, bus.wr_en, bus.bank, gen_cnt, state_dbg);
    end
    reset      = 1'b0;
    start_bank = 1'b0;
  endtask

  task automatic test_single_gen();
    run_scenario(1, 0, 20);
  endtask

  task automatic test_zero_gens();
    run_scenario(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_scenario(2, 0, 0);
  endtask

  task automatic test_edge_flags();
    run_scenario(1, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    run_scenario(1, 30, 5);
  endtask

  task automatic test_restart();
    run_scenario(1, 0, 0);
  endtask

  initial begin
    for (int ai = 0; ai < 64; ai++) begin
      board[0][ai] = 1'b0;
      board[1][ai] = 1'($urandom_range(1, 0));
    end
    board[0][26] = 1'b1;
    board[0][27] = 1'b1;
    board[0][28] = 1'b1;
    test_reset();
    test_single_gen();
    test_zero_gens();
    test_back_to_back();
    test_edge_flags();
    test_reset_mid_run();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
